// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and the execute core.
// The master modport is the fetch unit's view; the slave modport is the environment's.
interface instruction_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fetch_instruction;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output fetch_valid,
    output fetch_pc,
    output fetch_instruction,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    input  fetch_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  fetch_valid,
    input  fetch_pc,
    input  fetch_instruction,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    output fetch_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: in-order word reads into a prefetch FIFO of {pc, instruction},
// presented to the core over valid/ready, with flush-and-restart on redirect.
module instruction_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] reqPc_q, reqPc_d;
  logic [XLEN-1:0] rspPc_q, rspPc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [XLEN-1:0] pcMem_q    [FIFO_DEPTH];
  logic [31:0]     instrMem_q [FIFO_DEPTH];

  logic [CW:0]     inUse;
  logic [XLEN-1:0] redirectPc;
  logic            reqValid;
  logic            accept;
  logic            rspKept;
  logic            rspDropped;
  logic            push;
  logic            pop;
  logic            fifoValid;

  // Credits count buffered entries plus kept requests in flight, from registered state only,
  // so a pop frees its slot one cycle later and overflow cannot occur.
  assign inUse      = (CW + 1)'(count_q) + (CW + 1)'(outstanding_q);
  assign reqValid   = !rst && !bus.redirect_valid && (inUse < DEPTH_C);
  assign accept     = reqValid && bus.imem_req_ready;
  assign redirectPc = bus.redirect_pc & ~XLEN'(3);

  assign rspDropped = bus.imem_rsp_valid && (discard_q != '0);
  assign rspKept    = bus.imem_rsp_valid && (discard_q == '0);
  assign fifoValid  = (count_q != '0);
  assign push       = rspKept && !bus.redirect_valid;
  assign pop        = fifoValid && bus.fetch_ready && !bus.redirect_valid;

  // Outstanding tracks only responses that will be kept; a redirect moves every
  // in-flight request (minus one arriving right now) into the discard count.
  always_comb begin
    reqPc_d       = reqPc_q;
    rspPc_d       = rspPc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    if (bus.redirect_valid) begin
      reqPc_d       = redirectPc;
      rspPc_d       = redirectPc;
      outstanding_d = '0;
      discard_d     = outstanding_q + discard_q - CW'(bus.imem_rsp_valid);
      count_d       = '0;
      wrPtr_d       = '0;
      rdPtr_d       = '0;
    end else begin
      if (accept) begin
        reqPc_d = reqPc_q + XLEN'(4);
      end
      if (push) begin
        rspPc_d = rspPc_q + XLEN'(4);
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      outstanding_d = outstanding_q + CW'(accept) - CW'(rspKept);
      discard_d     = discard_q - CW'(rspDropped);
      count_d       = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reqPc_q       <= RESET_PC;
      rspPc_q       <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
    end else begin
      reqPc_q       <= reqPc_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pcMem_q[wrPtr_q]    <= rspPc_q;
      instrMem_q[wrPtr_q] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid    = reqValid;
  assign bus.imem_req_addr     = reqPc_q;
  assign bus.fetch_valid       = fifoValid;
  assign bus.fetch_pc          = fifoValid ? pcMem_q[rdPtr_q] : '0;
  assign bus.fetch_instruction = fifoValid ? instrMem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: queue-based memory/FIFO reference model
// plus directed scenarios and a randomized run.
module tb_instruction_fetch_unit;

  localparam int              XLEN     = 32;
  localparam int              DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_unit_if #(.XLEN(XLEN)) bus ();

  instruction_fetch_unit #(
    .XLEN       (XLEN),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors      = 0;
  int          checks      = 0;
  int          cyc         = 0;
  int          latency     = 1;
  int          acceptCount = 0;
  bit          modelValid  = 1'b0;
  bit          expReqValid;
  int          kept;
  req_t        inflight[$];
  ent_t        fifoQ[$];
  req_t        rspReq;
  ent_t        newEnt;
  logic [31:0] nextReqPc = RESET_PC;

  always #5 clk = ~clk;

  // Memory contents: word i holds the value i.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // In-order memory: the oldest request answers once its latency has elapsed.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memWord(inflight[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // Reference model: compares outputs mid-cycle, then applies this cycle's events.
  always @(negedge clk) begin
    if (modelValid) begin
      kept = 0;
      foreach (inflight[i]) if (!inflight[i].stale) kept++;
      expReqValid = !rst && !bus.redirect_valid && ((fifoQ.size() + kept) < DEPTH);
      checks++;
      if (bus.imem_req_valid !== expReqValid) begin
        errors++;
        $display("[TB] FAIL req_valid: got %b expected %b at cycle %0d", bus.imem_req_valid, expReqValid, cyc);
      end
      checks++;
      if (bus.imem_req_addr !== nextReqPc) begin
        errors++;
        $display("[TB] FAIL req_addr: got %h expected %h at cycle %0d", bus.imem_req_addr, nextReqPc, cyc);
      end
      checks++;
      if (bus.fetch_valid !== (fifoQ.size() != 0)) begin
        errors++;
        $display("[TB] FAIL fetch_valid: got %b expected %b at cycle %0d", bus.fetch_valid, fifoQ.size() != 0, cyc);
      end
      if (fifoQ.size() != 0) begin
        checks++;
        if (bus.fetch_pc !== fifoQ[0].pc || bus.fetch_instruction !== fifoQ[0].instr) begin
          errors++;
          $display("[TB] FAIL fetch_head: got pc=%h instr=%h expected pc=%h instr=%h at cycle %0d",
                   bus.fetch_pc, bus.fetch_instruction, fifoQ[0].pc, fifoQ[0].instr, cyc);
        end
      end else begin
        checks++;
        if (bus.fetch_pc !== 32'h0 || bus.fetch_instruction !== 32'h0) begin
          errors++;
          $display("[TB] FAIL fetch_empty: got pc=%h instr=%h expected zeros at cycle %0d",
                   bus.fetch_pc, bus.fetch_instruction, cyc);
        end
      end
    end
    if (rst) begin
      fifoQ.delete();
      inflight.delete();
      nextReqPc  = RESET_PC;
      modelValid = 1'b1;
    end else if (modelValid) begin
      if (bus.imem_rsp_valid && inflight.size() > 0) begin
        rspReq = inflight.pop_front();
        if (!rspReq.stale && !bus.redirect_valid) begin
          newEnt.pc    = rspReq.addr;
          newEnt.instr = memWord(rspReq.addr);
          fifoQ.push_back(newEnt);
          checks++;
          if (fifoQ.size() > DEPTH) begin
            errors++;
            $display("[TB] FAIL overflow: got occupancy %0d expected at most %0d at cycle %0d", fifoQ.size(), DEPTH, cyc);
          end
        end
      end
      if (bus.redirect_valid) begin
        fifoQ.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        nextReqPc = bus.redirect_pc & ~32'h3;
      end else if (bus.fetch_valid && bus.fetch_ready && fifoQ.size() > 0) begin
        void'(fifoQ.pop_front());
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        rspReq.addr  = nextReqPc;
        rspReq.due   = cyc + latency;
        rspReq.stale = 1'b0;
        inflight.push_back(rspReq);
        nextReqPc = nextReqPc + 32'd4;
        acceptCount++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    step();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    acceptCount = 0;
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b0;
    bus.fetch_ready    = 1'b0;
    latency            = 1;
    step();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_valid: got %b expected 0", bus.fetch_valid); end
    checks++;
    if (bus.fetch_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_fetch_pc: got %h expected 0", bus.fetch_pc); end
    checks++;
    if (bus.fetch_instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_fetch_instr: got %h expected 0", bus.fetch_instruction); end
    checks++;
    if (bus.imem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL reset_req_addr: got %h expected %h", bus.imem_req_addr, RESET_PC); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_request: got %b expected 1", bus.imem_req_valid); end
  endtask

  task automatic test_streaming();
    int          n = 0;
    logic [31:0] pcs[$];
    latency            = 1;
    bus.imem_req_ready = 1'b1;
    bus.fetch_ready    = 1'b1;
    doReset();
    repeat (30) begin
      @(negedge clk);
      if (bus.fetch_valid) begin
        n++;
        pcs.push_back(bus.fetch_pc);
      end
    end
    checks++;
    if (n != 28) begin errors++; $display("[TB] FAIL stream_throughput: got %0d expected 28", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pcs.size() <= k || pcs[k] !== 32'(4 * k)) begin
        errors++;
        $display("[TB] FAIL stream_pc%0d: got %h expected %h", k, (pcs.size() > k) ? pcs[k] : 32'hx, 32'(4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs[$];
    bus.fetch_ready    = 1'b0;
    bus.imem_req_ready = 1'b1;
    latency            = 1;
    doReset();
    repeat (12) @(negedge clk);
    checks++;
    if (acceptCount != DEPTH) begin errors++; $display("[TB] FAIL bp_requests: got %0d expected %0d", acceptCount, DEPTH); end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_valid: got %b expected 0", bus.imem_req_valid); end
    step();
    bus.fetch_ready = 1'b1;
    for (int i = 0; i < 12 && pcs.size() < 4; i++) begin
      @(negedge clk);
      if (bus.fetch_valid) pcs.push_back(bus.fetch_pc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pcs.size() <= k || pcs[k] !== 32'(4 * k)) begin
        errors++;
        $display("[TB] FAIL bp_drain_pc%0d: got %h expected %h", k, (pcs.size() > k) ? pcs[k] : 32'hx, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    bit found = 1'b0;
    latency            = 8;
    bus.imem_req_ready = 1'b1;
    bus.fetch_ready    = 1'b1;
    doReset();
    step();
    step();
    step();
    checks++;
    if (acceptCount != 3) begin errors++; $display("[TB] FAIL redir_outstanding: got %0d expected 3", acceptCount); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.fetch_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL redir_timeout: got no fetch expected pc 00000100");
    end else if (bus.fetch_pc !== 32'h100 || bus.fetch_instruction !== 32'h40) begin
      errors++;
      $display("[TB] FAIL redir_first: got pc=%h instr=%h expected pc=00000100 instr=00000040", bus.fetch_pc, bus.fetch_instruction);
    end
  endtask

  task automatic test_redirect_with_response();
    bit found = 1'b0;
    latency            = 2;
    bus.imem_req_ready = 1'b1;
    bus.fetch_ready    = 1'b1;
    doReset();
    step();
    bus.imem_req_ready = 1'b0;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.fetch_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL rsp_redir_timeout: got no fetch expected pc 00000300");
    end else if (bus.fetch_pc !== 32'h300 || bus.fetch_instruction !== 32'hC0) begin
      errors++;
      $display("[TB] FAIL rsp_redir_first: got pc=%h instr=%h expected pc=00000300 instr=000000c0", bus.fetch_pc, bus.fetch_instruction);
    end
  endtask

  task automatic test_align();
    bit found = 1'b0;
    latency            = 1;
    bus.imem_req_ready = 1'b1;
    bus.fetch_ready    = 1'b1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req_addr !== 32'h200) begin errors++; $display("[TB] FAIL align_req_addr: got %h expected 00000200", bus.imem_req_addr); end
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.fetch_valid) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found || bus.fetch_pc !== 32'h200) begin
      errors++;
      $display("[TB] FAIL align_fetch_pc: got %h expected 00000200", bus.fetch_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[$];
    logic [31:0] expPc;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 30 && pcs.size() < 3; i++) begin
      @(negedge clk);
      if (bus.fetch_valid) pcs.push_back(bus.fetch_pc);
    end
    expPc = 32'hFFFF_FFF8;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pcs.size() <= k || pcs[k] !== expPc) begin
        errors++;
        $display("[TB] FAIL wrap_pc%0d: got %h expected %h", k, (pcs.size() > k) ? pcs[k] : 32'hx, expPc);
      end
      expPc = expPc + 32'd4;
    end
  endtask

  task automatic test_stall_and_reset();
    logic [31:0] holdAddr;
    bit          found = 1'b0;
    latency            = 1;
    bus.imem_req_ready = 1'b1;
    bus.fetch_ready    = 1'b1;
    doReset();
    repeat (5) step();
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    holdAddr = nextReqPc;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req_addr !== holdAddr) begin errors++; $display("[TB] FAIL stall_addr_hold: got %h expected %h", bus.imem_req_addr, holdAddr); end
    end
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_push: got %b expected 0", bus.fetch_valid); end
    step();
    bus.imem_req_ready = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", bus.fetch_valid); end
    checks++;
    if (bus.imem_req_addr !== RESET_PC || bus.imem_req_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_request: got addr=%h valid=%b expected addr=%h valid=1", bus.imem_req_addr, bus.imem_req_valid, RESET_PC);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.fetch_valid) found = 1'b1;
    end
    checks++;
    if (!found || bus.fetch_pc !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL midreset_first_pc: got %h expected %h", bus.fetch_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    int handshakes = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.fetch_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 29) == 0);
      bus.redirect_pc    = $urandom;
      if ($urandom_range(0, 99) == 0) latency = $urandom_range(1, 5);
      rst = ($urandom_range(0, 599) == 0);
      @(negedge clk);
      if (bus.fetch_valid && bus.fetch_ready && !bus.redirect_valid && !rst) handshakes++;
    end
    step();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.fetch_ready    = 1'b1;
    repeat (20) step();
    checks++;
    if (handshakes == 0) begin errors++; $display("[TB] FAIL random_progress: got 0 fetches expected some"); end
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.fetch_ready    = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_with_response();
    test_align();
    test_wrap();
    test_stall_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
